// File: rtl/cart_pkg.sv
// Shared cartridge definitions: loader FSM encoding, error codes, iNES header
// layout and the mapper_config bit map that cart_config decodes.
package cart_pkg;

  typedef logic [2:0] loader_state_t;

  localparam loader_state_t ST_IDLE    = 3'd0;
  localparam loader_state_t ST_HDR     = 3'd1;
  localparam loader_state_t ST_TRAINER = 3'd2;
  localparam loader_state_t ST_PRG     = 3'd3;
  localparam loader_state_t ST_CHR     = 3'd4;
  localparam loader_state_t ST_DONE    = 3'd5;
  localparam loader_state_t ST_ERR     = 3'd6;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_MAGIC = 2'd1;
  localparam logic [1:0] ERR_SIZE  = 2'd2;

  // "NES\x1A", header byte i lives at bits [8*i +: 8]
  localparam logic [31:0] INES_MAGIC = 32'h1A53_454E;

  localparam int HDR_LEN       = 16;
  localparam int HDR_PRG_UNITS = 4;
  localparam int HDR_CHR_UNITS = 5;
  localparam int HDR_FLAGS6    = 6;
  localparam int HDR_FLAGS7    = 7;
  localparam int TRAINER_LEN   = 512;

  localparam int F6_MIRROR      = 0;
  localparam int F6_BATTERY     = 1;
  localparam int F6_TRAINER     = 2;
  localparam int F6_FOUR_SCREEN = 3;

  localparam int CFG_MIRROR_V    = 0;
  localparam int CFG_BATTERY     = 1;
  localparam int CFG_FOUR_SCREEN = 2;
  localparam int CFG_CHR_RAM     = 3;
  localparam int CFG_MAPPER_LSB  = 8;

  // Smallest (2^k - 1) covering a non-zero byte count: smear the top bit of bytes-1 downward.
  function automatic logic [31:0] pow2_mask(input logic [31:0] bytes);
    logic [31:0] m;
    m = bytes - 32'd1;
    m = m | (m >> 1);
    m = m | (m >> 2);
    m = m | (m >> 4);
    m = m | (m >> 8);
    m = m | (m >> 16);
    return m;
  endfunction

endpackage

// File: rtl/bram_byte_writer.sv
// Turns one accepted image byte into a registered single-lane write on a
// 32-bit byte-addressed BRAM port.
module bram_byte_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic [31:0] idx,
  input  logic [7:0]  data,
  output logic [31:0] addr,
  output logic [3:0]  we,
  output logic [31:0] dout,
  output logic        en
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      we   <= '0;
      dout <= '0;
      en   <= 1'b0;
    end else begin
      en <= stb;
      we <= stb ? (4'b0001 << idx[1:0]) : 4'b0000;
      if (stb) begin
        addr <= {idx[31:2], 2'b00};
        dout <= {4{data}};
      end
    end
  end

endmodule

// File: rtl/ines_loader.sv
// iNES image loader: parses the 16-byte header, skips an optional trainer and
// streams PRG then CHR payload into the cartridge BRAMs.
module ines_loader
  import cart_pkg::*;
#(
  parameter int          PRG_AW      = 15,
  parameter int          CHR_AW      = 13,
  parameter logic [31:0] PRGRAM_MASK = 32'h1FFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] BRAM_PRG_addr,
  output logic        BRAM_PRG_clk,
  output logic [31:0] BRAM_PRG_dout,
  output logic        BRAM_PRG_en,
  output logic        BRAM_PRG_rst,
  output logic [3:0]  BRAM_PRG_we,
  output logic [31:0] BRAM_CHR_addr,
  output logic        BRAM_CHR_clk,
  output logic [31:0] BRAM_CHR_dout,
  output logic        BRAM_CHR_en,
  output logic        BRAM_CHR_rst,
  output logic [3:0]  BRAM_CHR_we,
  output logic [31:0] mapper_config,
  output logic [31:0] PRG_mask,
  output logic [31:0] CHR_mask,
  output logic [31:0] PRGRAM_mask,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  loader_state_t state;
  logic [31:0]   cnt;
  logic [7:0]    prg_units, chr_units, flags6;
  logic [3:0]    mapper_hi;
  logic [31:0]   prg_bytes, chr_bytes, cfg_next;
  logic          xfer, can_start, size_bad, prg_stb, chr_stb;

  assign s_ready = (state == ST_HDR) || (state == ST_TRAINER) ||
                   (state == ST_PRG) || (state == ST_CHR);
  assign busy      = s_ready;
  assign done      = (state == ST_DONE);
  assign xfer      = s_valid && s_ready;
  assign can_start = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));

  assign prg_bytes = {10'b0, prg_units, 14'b0};
  assign chr_bytes = {11'b0, chr_units, 13'b0};
  assign size_bad  = (prg_units == 8'd0) || (prg_bytes > (32'd1 << PRG_AW)) ||
                     (chr_bytes > (32'd1 << CHR_AW));

  assign prg_stb = xfer && (state == ST_PRG);
  assign chr_stb = xfer && (state == ST_CHR);

  assign PRGRAM_mask  = PRGRAM_MASK;
  assign BRAM_PRG_clk = clk;
  assign BRAM_CHR_clk = clk;
  assign BRAM_PRG_rst = 1'b0;
  assign BRAM_CHR_rst = 1'b0;

  always_comb begin
    cfg_next                          = '0;
    cfg_next[CFG_MIRROR_V]            = flags6[F6_MIRROR];
    cfg_next[CFG_BATTERY]             = flags6[F6_BATTERY];
    cfg_next[CFG_FOUR_SCREEN]         = flags6[F6_FOUR_SCREEN];
    cfg_next[CFG_CHR_RAM]             = (chr_units == 8'd0);
    cfg_next[CFG_MAPPER_LSB +: 8]     = {mapper_hi, flags6[7:4]};
  end

  // NOTE: state updates use non-blocking assignments so every branch sees pre-edge
  // values; reset is synchronous, so rst_n appears only inside the clocked block.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      err           <= ERR_NONE;
      prg_units     <= '0;
      chr_units     <= '0;
      flags6        <= '0;
      mapper_hi     <= '0;
      mapper_config <= '0;
      PRG_mask      <= '0;
      CHR_mask      <= '0;
    end else if (can_start) begin
      state         <= ST_HDR;
      cnt           <= '0;
      err           <= ERR_NONE;
      mapper_config <= '0;
      PRG_mask      <= '0;
      CHR_mask      <= '0;
    end else if (xfer) begin
      cnt <= cnt + 32'd1;
      case (state)
        ST_HDR: begin
          if (cnt < 32'd4 && s_data != INES_MAGIC[{cnt[1:0], 3'b000} +: 8]) begin
            state <= ST_ERR;
            err   <= ERR_MAGIC;
          end
          if (cnt == HDR_PRG_UNITS) prg_units <= s_data;
          if (cnt == HDR_CHR_UNITS) chr_units <= s_data;
          if (cnt == HDR_FLAGS6)    flags6    <= s_data;
          if (cnt == HDR_FLAGS7)    mapper_hi <= s_data[7:4];
          if (cnt == HDR_LEN - 1) begin
            cnt <= '0;
            if (size_bad) begin
              state <= ST_ERR;
              err   <= ERR_SIZE;
            end else begin
              mapper_config <= cfg_next;
              PRG_mask      <= pow2_mask(prg_bytes);
              CHR_mask      <= (chr_units == 8'd0) ? 32'h1FFF : pow2_mask(chr_bytes);
              state         <= flags6[F6_TRAINER] ? ST_TRAINER : ST_PRG;
            end
          end
        end
        ST_TRAINER: begin
          if (cnt == TRAINER_LEN - 1) begin
            cnt   <= '0;
            state <= ST_PRG;
          end
        end
        ST_PRG: begin
          if (cnt == prg_bytes - 32'd1) begin
            cnt   <= '0;
            state <= (chr_units == 8'd0) ? ST_DONE : ST_CHR;
          end
        end
        ST_CHR: begin
          if (cnt == chr_bytes - 32'd1) state <= ST_DONE;
        end
        default: ;
      endcase
    end
  end

  bram_byte_writer u_prg_writer (
    .clk   (clk),
    .rst_n (rst_n),
    .stb   (prg_stb),
    .idx   (cnt),
    .data  (s_data),
    .addr  (BRAM_PRG_addr),
    .we    (BRAM_PRG_we),
    .dout  (BRAM_PRG_dout),
    .en    (BRAM_PRG_en)
  );

  bram_byte_writer u_chr_writer (
    .clk   (clk),
    .rst_n (rst_n),
    .stb   (chr_stb),
    .idx   (cnt),
    .data  (s_data),
    .addr  (BRAM_CHR_addr),
    .we    (BRAM_CHR_we),
    .dout  (BRAM_CHR_dout),
    .en    (BRAM_CHR_en)
  );

endmodule

// File: tb/tb_ines_loader.sv
// Directed bench for ines_loader: full NROM images, trainer skip, header errors,
// start-while-busy, random s_valid gaps and mid-load reset.
module tb_ines_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] BRAM_PRG_addr, BRAM_PRG_dout, BRAM_CHR_addr, BRAM_CHR_dout;
  logic        BRAM_PRG_clk, BRAM_PRG_en, BRAM_PRG_rst;
  logic        BRAM_CHR_clk, BRAM_CHR_en, BRAM_CHR_rst;
  logic [3:0]  BRAM_PRG_we, BRAM_CHR_we;
  logic [31:0] mapper_config, PRG_mask, CHR_mask, PRGRAM_mask;
  logic        busy, done;
  logic [1:0]  err;

  ines_loader dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .BRAM_PRG_addr (BRAM_PRG_addr),
    .BRAM_PRG_clk  (BRAM_PRG_clk),
    .BRAM_PRG_dout (BRAM_PRG_dout),
    .BRAM_PRG_en   (BRAM_PRG_en),
    .BRAM_PRG_rst  (BRAM_PRG_rst),
    .BRAM_PRG_we   (BRAM_PRG_we),
    .BRAM_CHR_addr (BRAM_CHR_addr),
    .BRAM_CHR_clk  (BRAM_CHR_clk),
    .BRAM_CHR_dout (BRAM_CHR_dout),
    .BRAM_CHR_en   (BRAM_CHR_en),
    .BRAM_CHR_rst  (BRAM_CHR_rst),
    .BRAM_CHR_we   (BRAM_CHR_we),
    .mapper_config (mapper_config),
    .PRG_mask      (PRG_mask),
    .CHR_mask      (CHR_mask),
    .PRGRAM_mask   (PRGRAM_mask),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int mism = 0;
  int prg_wr_total = 0;
  int chr_wr_total = 0;
  logic [31:0] w5_addr, w5_dout;
  logic [3:0]  w5_we;

  // Strobes are counted at the edge that ends the cycle they were high in.
  always @(posedge clk) begin
    if (BRAM_PRG_en) prg_wr_total++;
    if (BRAM_CHR_en) chr_wr_total++;
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ready"},   {31'b0, s_ready}, 32'd0);
    check({tag, "_busy"},    {31'b0, busy}, 32'd0);
    check({tag, "_done"},    {31'b0, done}, 32'd0);
    check({tag, "_err"},     {30'b0, err}, 32'd0);
    check({tag, "_prg_en"},  {27'b0, BRAM_PRG_we, BRAM_PRG_en}, 32'd0);
    check({tag, "_chr_en"},  {27'b0, BRAM_CHR_we, BRAM_CHR_en}, 32'd0);
    check({tag, "_prg_addr"}, BRAM_PRG_addr | BRAM_PRG_dout, 32'd0);
    check({tag, "_chr_addr"}, BRAM_CHR_addr | BRAM_CHR_dout, 32'd0);
    check({tag, "_cfg"},     mapper_config, 32'd0);
    check({tag, "_masks"},   PRG_mask | CHR_mask, 32'd0);
    check({tag, "_pgrmask"}, PRGRAM_mask, 32'h0000_1FFF);
    check({tag, "_bram_rst"}, {30'b0, BRAM_PRG_rst, BRAM_CHR_rst}, 32'd0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called and returns at a negedge; on return the byte has been accepted and
  // its registered write (if any) is visible.
  task automatic push(input logic [7:0] b, input int gap);
    int waited;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      @(negedge clk);
      if (BRAM_PRG_en || BRAM_CHR_en) mism++;
    end
    s_data  = b;
    s_valid = 1'b1;
    waited  = 0;
    while (!s_ready && waited < 16) begin
      @(negedge clk);
      waited++;
    end
    if (!s_ready) mism++;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] b4, input logic [7:0] b5,
                          input logic [7:0] b6, input logic [7:0] b7);
    push(8'h4E, 0);
    push(8'h45, 0);
    push(8'h53, 0);
    push(8'h1A, 0);
    push(b4, 0);
    push(b5, 0);
    push(b6, 0);
    push(b7, 0);
    for (int i = 0; i < 8; i++) push(8'h00, 0);
  endtask

  // Payload byte n of a section carries n[7:0]; each must produce its own write.
  task automatic feed(input bit is_chr, input int first, input int nbytes, input bit gaps);
    logic [31:0] n32;
    int gap;
    for (int n = first; n < first + nbytes; n++) begin
      n32 = n;
      gap = 0;
      if (gaps && $urandom_range(0, 3) == 0) gap = int'($urandom_range(1, 2));
      push(n32[7:0], gap);
      if (is_chr) begin
        if (!(BRAM_CHR_en === 1'b1 && BRAM_PRG_en === 1'b0 &&
              BRAM_CHR_addr === {n32[31:2], 2'b00} &&
              BRAM_CHR_we === (4'b0001 << n32[1:0]) &&
              BRAM_CHR_dout === {4{n32[7:0]}})) mism++;
      end else begin
        if (!(BRAM_PRG_en === 1'b1 && BRAM_CHR_en === 1'b0 &&
              BRAM_PRG_addr === {n32[31:2], 2'b00} &&
              BRAM_PRG_we === (4'b0001 << n32[1:0]) &&
              BRAM_PRG_dout === {4{n32[7:0]}})) mism++;
        if (n == 5) begin
          w5_addr = BRAM_PRG_addr;
          w5_we   = BRAM_PRG_we;
          w5_dout = BRAM_PRG_dout;
        end
      end
    end
  endtask

  initial begin
    int p0, c0;

    // Reset
    repeat (3) @(negedge clk);
    check_reset("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", {31'b0, s_ready}, 32'd0);

    // NROM-256: 2x16K PRG, 1x8K CHR, vertical mirroring
    p0 = prg_wr_total; c0 = chr_wr_total; mism = 0;
    pulse_start();
    check("n256_busy_ready", {30'b0, busy, s_ready}, 32'd3);
    send_hdr(8'h02, 8'h01, 8'h01, 8'h00);
    check("n256_prg_mask_latched", PRG_mask, 32'h0000_7FFF);
    feed(1'b0, 0, 32768, 1'b0);
    check("n256_not_done_after_prg", {31'b0, done}, 32'd0);
    feed(1'b1, 0, 8192, 1'b0);
    check("n256_done_with_last_write", {30'b0, done, BRAM_CHR_en}, 32'd3);
    repeat (2) @(negedge clk);
    check("n256_prg_writes", prg_wr_total - p0, 32'd32768);
    check("n256_chr_writes", chr_wr_total - c0, 32'd8192);
    check("n256_w5_addr", w5_addr, 32'd4);
    check("n256_w5_we", {28'b0, w5_we}, 32'b0010);
    check("n256_w5_dout", w5_dout, 32'h0505_0505);
    check("n256_cfg", mapper_config, 32'h0000_0001);
    check("n256_prg_mask", PRG_mask, 32'h0000_7FFF);
    check("n256_chr_mask", CHR_mask, 32'h0000_1FFF);
    check("n256_status", {28'b0, err, busy, done}, 32'd1);
    check("n256_write_mismatches", mism, 32'd0);

    // Trainer skip, start ignored while busy, s_valid gaps, reset mid-PRG
    p0 = prg_wr_total; c0 = chr_wr_total; mism = 0;
    pulse_start();
    send_hdr(8'h01, 8'h00, 8'h04, 8'h00);
    for (int i = 0; i < 512; i++) push(8'hAA, 0);
    check("trn_no_write_on_528", {31'b0, BRAM_PRG_en}, 32'd0);
    push(8'h00, 0);
    check("trn_first_write_529", {BRAM_PRG_addr[27:0], BRAM_PRG_we}, 32'h0000_0001);
    check("trn_first_write_en", {31'b0, BRAM_PRG_en}, 32'd1);
    check("trn_writes_before_prg", prg_wr_total - p0, 32'd0);
    feed(1'b0, 1, 999, 1'b1);
    pulse_start();
    check("busy_start_ignored", {31'b0, busy}, 32'd1);
    check("busy_start_mask_kept", PRG_mask, 32'h0000_3FFF);
    feed(1'b0, 1000, 1000, 1'b1);
    check("gap_write_mismatches", mism, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset("midrst");
    rst_n = 1'b1;
    @(negedge clk);

    // Reload after reset: NROM-128, CHR-RAM
    p0 = prg_wr_total; c0 = chr_wr_total; mism = 0;
    pulse_start();
    send_hdr(8'h01, 8'h00, 8'h00, 8'h00);
    feed(1'b0, 0, 16384, 1'b0);
    check("n128_done_with_last_write", {30'b0, done, BRAM_PRG_en}, 32'd3);
    repeat (2) @(negedge clk);
    check("n128_prg_writes", prg_wr_total - p0, 32'd16384);
    check("n128_chr_writes", chr_wr_total - c0, 32'd0);
    check("n128_cfg", mapper_config, 32'h0000_0008);
    check("n128_prg_mask", PRG_mask, 32'h0000_3FFF);
    check("n128_chr_mask", CHR_mask, 32'h0000_1FFF);
    check("n128_write_mismatches", mism, 32'd0);

    // Bad magic in byte 2
    p0 = prg_wr_total; c0 = chr_wr_total;
    pulse_start();
    push(8'h4E, 0);
    push(8'h45, 0);
    check("magic_ok_so_far", {30'b0, err}, 32'd0);
    push(8'h54, 0);
    check("magic_err", {30'b0, err}, 32'd1);
    check("magic_flags", {29'b0, s_ready, busy, done}, 32'd0);
    check("magic_cfg_cleared", mapper_config, 32'd0);
    repeat (2) @(negedge clk);
    check("magic_no_writes", (prg_wr_total - p0) + (chr_wr_total - c0), 32'd0);

    // Oversized PRG, then a valid image
    p0 = prg_wr_total; c0 = chr_wr_total; mism = 0;
    pulse_start();
    check("size_err_cleared_by_start", {30'b0, err}, 32'd0);
    send_hdr(8'h04, 8'h01, 8'h00, 8'h00);
    check("size_err", {30'b0, err}, 32'd2);
    check("size_flags", {29'b0, s_ready, busy, done}, 32'd0);
    repeat (2) @(negedge clk);
    check("size_no_writes", (prg_wr_total - p0) + (chr_wr_total - c0), 32'd0);
    pulse_start();
    send_hdr(8'h01, 8'h01, 8'h13, 8'h20);
    feed(1'b0, 0, 16384, 1'b0);
    check("recov_not_done_after_prg", {31'b0, done}, 32'd0);
    feed(1'b1, 0, 8192, 1'b0);
    check("recov_done", {30'b0, err, done}, 32'd1);
    repeat (2) @(negedge clk);
    check("recov_prg_writes", prg_wr_total - p0, 32'd16384);
    check("recov_chr_writes", chr_wr_total - c0, 32'd8192);
    check("recov_cfg", mapper_config, 32'h0000_2103);
    check("recov_masks", {PRG_mask[15:0], CHR_mask[15:0]}, 32'h3FFF_1FFF);
    check("recov_write_mismatches", mism, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
